ctrl_time_sched: RTL
====================

CTRL_TIME_SCHED -- requirements
Module: ctrl_time_sched

Interface
REQ-001 Parameter NUM_EVT, default 11: number of schedule entries.
REQ-002 Parameter CNT_W, default 12: step counter and time width.
REQ-003 Parameter DATA_W, default `EXTENDED_SINGLE: value width.
REQ-004 Port clk  in  1: single clock, rising edge; the only clock.
REQ-005 Port rst_n  in  1: reset, asynchronous assert, active-low.
REQ-006 Port wr_en  in  1: host table write request.
REQ-007 Port wr_addr  in  4: entry index, 0..NUM_EVT-1.
REQ-008 Port wr_time  in  CNT_W: event time for entry.
REQ-009 Port wr_value  in  DATA_W: event value for entry.
REQ-010 Port wr_ready  out  1: table accepts writes; write occurs when wr_en&&wr_ready.
REQ-011 Port end_time  in  CNT_W: run length in steps, sampled on start.
REQ-012 Port start  in  1: one-cycle run request.
REQ-013 Port abort  in  1: stop run.
REQ-014 Port step_en  in  1: simulation-step tick; counter advances only on it.
REQ-015 Port sta  out  1: active-high clear pulse to the downstream time/value selector.
REQ-016 Port counter  out  CNT_W: current step index.
REQ-017 Port time_bus  out  NUM_EVT*CNT_W: entry k at bits [k*CNT_W +: CNT_W].
REQ-018 Port value_bus  out  NUM_EVT*DATA_W: entry k at bits [k*DATA_W +: DATA_W].
REQ-019 Port busy  out  1: high in ARM or RUN.
REQ-020 Port done  out  1: one-cycle pulse at normal run completion.
REQ-021 Port err  out  1: sticky error flag, cleared on start.

Function
REQ-022 FSM states IDLE, ARM, RUN, DONE; IDLE after reset.
REQ-023 IDLE: wr_ready=1; start -> ARM; start and wr_en in same cycle: write accepted, then ARM.
REQ-024 ARM lasts exactly one cycle; sta=1 only in ARM; counter=0; next RUN.
REQ-025 RUN: on step_en, if counter==end_time_latched-1 -> DONE, else counter+1.
REQ-026 end_time latched 0: ARM goes directly to DONE; counter stays 0.
REQ-027 DONE lasts one cycle; done=1; counter holds final value; next IDLE.
REQ-028 abort in ARM or RUN -> IDLE next cycle, no done pulse, counter holds; abort ignored in IDLE/DONE.
REQ-029 start ignored outside IDLE.
REQ-030 wr_ready=0 in ARM, RUN, DONE; table frozen during a run.
REQ-031 wr_addr >= NUM_EVT with wr_en&&wr_ready: no write, err set.
REQ-032 Counter never wraps; held at final value.
REQ-033 time_bus/value_bus are registered, reflect a write on the cycle after acceptance.

Reset
REQ-034 rst_n low: state IDLE, counter 0, sta 0, done 0, err 0, busy 0, all time/value entries 0.
REQ-035 rst_n mid-run aborts immediately; no done pulse after release.

Configuration
REQ-036 SCHED_ORDER_CHECK_EN defined: in ARM, any pair of nonzero times not strictly ascending by index, or any time > end_time, sets err; run still proceeds.
REQ-037 SCHED_ORDER_CHECK_EN undefined: no check logic; err set only by REQ-031.

Structure
REQ-038 Shared package holds FSM state encoding, NUM_EVT/CNT_W defaults, DATA_W via `EXTENDED_SINGLE from global_parameter.v.
REQ-039 One sub-module sched_table (register file with packed read buses); FSM and counter in top.

Verification
REQ-040 Write entry 0 time=5 value=0x3FF0000000000000 -> time_bus[11:0]=5, value_bus[63:0] match next cycle.
REQ-041 end_time=10, start, step_en every cycle -> sta one cycle, counter 0..9, done after step at 9, busy low after.
REQ-042 end_time=0, start -> ARM then DONE, done pulse, counter=0.
REQ-043 Abort at counter=4 -> IDLE, counter=4, no done; wr_ready=1.
REQ-044 Write wr_addr=12 -> no entry changes, err=1; next start clears err.
REQ-045 With SCHED_ORDER_CHECK_EN, times 8 then 3 at entries 0,1 -> err=1 after ARM; run completes.

Source files
------------

// File: rtl/ctrl_time_sched_pkg.sv
// Shared definitions for the time scheduler: size defaults and FSM state codes.
// DATA_W follows `EXTENDED_SINGLE (normally from global_parameter.v); a 64-bit
// fallback keeps this slice self-contained.
// Optional feature macro: SCHED_ORDER_CHECK_EN (see ctrl_time_sched.sv).
`ifndef EXTENDED_SINGLE
`define EXTENDED_SINGLE 64
`endif

package ctrl_time_sched_pkg;

   localparam int unsigned NUM_EVT_DEF = 11;
   localparam int unsigned CNT_W_DEF   = 12;
   localparam int unsigned DATA_W_DEF  = `EXTENDED_SINGLE;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ARM  = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/ctrl_time_sched_table.sv
// sched_table: host-written schedule register file (time/value per entry),
// exposed as packed, registered read buses.
module sched_table
   import ctrl_time_sched_pkg::*;
#(
   parameter int unsigned NUM_EVT = NUM_EVT_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      we,
   input  logic [3:0]                addr,
   input  logic [CNT_W-1:0]          wtime,
   input  logic [DATA_W-1:0]         wvalue,
   output logic [NUM_EVT*CNT_W-1:0]  time_bus,
   output logic [NUM_EVT*DATA_W-1:0] value_bus
);

   // Entry write: only the addressed slice updates; the caller guarantees addr is in range.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         time_bus  <= '0;
         value_bus <= '0;
      end else if (we) begin
         for (int unsigned k = 0; k < NUM_EVT; k++) begin
            if (32'(addr) == k) begin
               time_bus[k*CNT_W +: CNT_W]    <= wtime;
               value_bus[k*DATA_W +: DATA_W] <= wvalue;
            end
         end
      end
   end

endmodule

// File: rtl/ctrl_time_sched.sv
// ctrl_time_sched: run controller for a step-driven event schedule.
// IDLE accepts table writes; start arms a run (one-cycle sta clear pulse),
// the counter advances on step_en until end_time-1, then a one-cycle done.
// Optional macro SCHED_ORDER_CHECK_EN: table sanity check while armed.
module ctrl_time_sched
   import ctrl_time_sched_pkg::*;
#(
   parameter int unsigned NUM_EVT = NUM_EVT_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_en,
   input  logic [3:0]                wr_addr,
   input  logic [CNT_W-1:0]          wr_time,
   input  logic [DATA_W-1:0]         wr_value,
   output logic                      wr_ready,
   input  logic [CNT_W-1:0]          end_time,
   input  logic                      start,
   input  logic                      abort,
   input  logic                      step_en,
   output logic                      sta,
   output logic [CNT_W-1:0]          counter,
   output logic [NUM_EVT*CNT_W-1:0]  time_bus,
   output logic [NUM_EVT*DATA_W-1:0] value_bus,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   logic [1:0]       state_q;
   logic [CNT_W-1:0] end_q;
   logic             wr_acc;
   logic             addr_ok;
   logic             bad_wr;
   logic             order_err;

   assign wr_ready = (state_q == ST_IDLE);
   assign sta      = (state_q == ST_ARM);
   assign busy     = (state_q == ST_ARM) || (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);
   assign wr_acc   = wr_en && wr_ready;
   assign addr_ok  = (32'(wr_addr) < NUM_EVT);
   assign bad_wr   = wr_acc && !addr_ok;

   sched_table #(
      .NUM_EVT (NUM_EVT),
      .CNT_W   (CNT_W),
      .DATA_W  (DATA_W)
   ) u_table (
      .clk       (clk),
      .rst_n     (rst_n),
      .we        (wr_acc && addr_ok),
      .addr      (wr_addr),
      .wtime     (wr_time),
      .wvalue    (wr_value),
      .time_bus  (time_bus),
      .value_bus (value_bus)
   );

`ifdef SCHED_ORDER_CHECK_EN
   // Flag any nonzero pair not strictly ascending by index, or any time past end.
   always_comb begin
      order_err = 1'b0;
      for (int unsigned i = 0; i < NUM_EVT; i++) begin
         if (time_bus[i*CNT_W +: CNT_W] > end_q) order_err = 1'b1;
         for (int unsigned j = i + 1; j < NUM_EVT; j++) begin
            if ((time_bus[i*CNT_W +: CNT_W] != '0) && (time_bus[j*CNT_W +: CNT_W] != '0) &&
                (time_bus[i*CNT_W +: CNT_W] >= time_bus[j*CNT_W +: CNT_W]))
               order_err = 1'b1;
         end
      end
   end
`else
   assign order_err = 1'b0;
`endif

   // Run FSM, step counter and end_time latch; counter holds on abort and completion.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         counter <= '0;
         end_q   <= '0;
      end else begin
         case (state_q)
            ST_IDLE: if (start) begin
               state_q <= ST_ARM;
               counter <= '0;
               end_q   <= end_time;
            end
            ST_ARM: begin
               if (abort)             state_q <= ST_IDLE;
               else if (end_q == '0)  state_q <= ST_DONE;
               else                   state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (abort) state_q <= ST_IDLE;
               else if (step_en) begin
                  if (counter == end_q - CNT_W'(1)) state_q <= ST_DONE;
                  else                               counter <= counter + CNT_W'(1);
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Sticky error: set by an out-of-range write or a failed table check, cleared on start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err <= 1'b0;
      else if (bad_wr || (sta && order_err)) err <= 1'b1;
      else if (wr_ready && start) err <= 1'b0;
   end

endmodule
